fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: issues one imem read per cycle, buffers returned
// instructions in a 2-entry FIFO and presents the head to decode.
module fetch_stage #(
   parameter int unsigned BUF_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [31:0] pc_next,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
);

   localparam logic [2:0] DEPTH_W = 3'(BUF_DEPTH);

   logic [1:0]  count_q, count_d;
   logic        inflight_q, inflight_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [31:0] instr_q [2];
   logic [31:0] instr_d [2];
   logic [31:0] ipc_q [2];
   logic [31:0] ipc_d [2];

   logic        pop;
   logic        push;
   logic        issue;
   logic [2:0]  occ;

   // Decode-side view of the FIFO head; NOP/zero when empty.
   always_comb begin
      id_valid = (count_q != 2'd0);
      id_instr = NOP_INSTR;
      id_pc    = '0;
      if (id_valid) begin
         id_instr = instr_q[rd_ptr_q];
         id_pc    = ipc_q[rd_ptr_q];
      end
      id_pc_plus4 = id_pc + 32'd4;
   end

   // Issue decision, PC selection and next FIFO/in-flight state.
   always_comb begin
      pop   = id_valid & id_ready;
      push  = inflight_q & ~redirect_valid;
      // Occupancy counts the in-flight fetch and credits a same-cycle pop.
      occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue = ~rst & ~redirect_valid & (occ < DEPTH_W);

      imem_req  = issue;
      imem_addr = pc;

      if (rst)
         pc_next = pc;
      else if (redirect_valid)
         pc_next = {redirect_pc[31:2], 2'b00};
      else if (issue)
         pc_next = pc + 32'd4;
      else
         pc_next = pc;

      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      instr_d    = instr_q;
      ipc_d      = ipc_q;
      inflight_d = issue;
      req_pc_d   = issue ? pc : req_pc_q;

      if (redirect_valid) begin
         count_d  = '0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) begin
            instr_d[wr_ptr_q] = imem_rdata;
            ipc_d[wr_ptr_q]   = req_pc_q;
            wr_ptr_d          = ~wr_ptr_q;
         end
         if (pop)
            rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         inflight_q <= 1'b0;
         req_pc_q   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         instr_q    <= '{default: '0};
         ipc_q      <= '{default: '0};
      end else begin
         count_q    <= count_d;
         inflight_q <= inflight_d;
         req_pc_q   <= req_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         instr_q    <= instr_d;
         ipc_q      <= ipc_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a queue-based reference model;
// the bench also acts as the PC register and the instruction memory.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = '0;
   logic [31:0] pc_next;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_stage #(.BUF_DEPTH(2), .NOP_INSTR(32'h00000013)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
   );

   always #5 clk = ~clk;

   // Reference model state
   typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
   ent_t        q[$];
   logic        m_inflight = 1'b0;
   logic [31:0] m_req_pc = '0;
   logic [31:0] m_pc = '0;
   logic [31:0] salt = 32'hA5A5A5A5;

   // Expected combinational outputs for the current cycle
   logic        e_valid, e_pop, e_req;
   logic [31:0] e_instr, e_pc, e_pc4, e_pcn;

   task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
      rst = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
      #1;
   endtask

   task automatic model_eval();
      int occ;
      e_valid = !rst && (q.size() != 0);
      e_instr = e_valid ? q[0].instr : NOP;
      e_pc    = e_valid ? q[0].pc : 32'h0;
      e_pc4   = e_pc + 32'd4;
      e_pop   = e_valid && id_ready;
      occ     = q.size() + (m_inflight ? 1 : 0) - (e_pop ? 1 : 0);
      e_req   = !rst && !redirect_valid && (occ < 2);
      if (rst)                 e_pcn = m_pc;
      else if (redirect_valid) e_pcn = {redirect_pc[31:2], 2'b00};
      else if (e_req)          e_pcn = m_pc + 32'd4;
      else                     e_pcn = m_pc;
   endtask

   task automatic clock_edge();
      logic [31:0] resp;
      resp = imem_rdata;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_inflight = 1'b0;
         m_req_pc   = '0;
         m_pc       = '0;
      end else begin
         if (e_pop) void'(q.pop_front());
         if (redirect_valid) q.delete();
         else if (m_inflight) q.push_back('{resp, m_req_pc});
         if (e_req) m_req_pc = m_pc;
         m_inflight = e_req;
         m_pc       = e_pcn;
      end
      #1;
      pc         = m_pc;
      imem_rdata = m_inflight ? (m_req_pc ^ salt) : $urandom;
   endtask

   function automatic logic [161:0] obs();
      return {id_valid, id_instr, id_pc, id_pc_plus4, imem_req, imem_addr, pc_next};
   endfunction

   function automatic logic [161:0] expv();
      return {e_valid, e_instr, e_pc, e_pc4, e_req, m_pc, e_pcn};
   endfunction

   task automatic test_reset();
      drive(1'b1, 1'b0, '0, 1'b1);
      model_eval();
      n_cmp++;
      if ({id_valid, id_instr, id_pc, imem_req, pc_next} !== {1'b0, NOP, 32'h0, 1'b0, m_pc}) begin
         n_bad++;
         $display("FAIL reset_state got v=%b i=%h p=%h rq=%b pn=%h want v=0 i=%h p=0 rq=0 pn=%h",
                  id_valid, id_instr, id_pc, imem_req, pc_next, NOP, m_pc);
      end
      clock_edge();
      drive(1'b1, 1'b0, '0, 1'b1);
      model_eval();
      n_cmp++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL reset_hold got %h want %h", obs(), expv());
      end
      clock_edge();
   endtask

   task automatic test_stream(input string nm);
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         model_eval();
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++; $display("FAIL %s_model cyc=%0d got %h want %h", nm, c, obs(), expv());
         end
         if (c >= 2) begin
            n_cmp++;
            if ({id_valid, id_pc, id_instr} !== {1'b1, 32'(4 * (c - 2)), 32'(4 * (c - 2)) ^ 32'hA5A5A5A5}) begin
               n_bad++;
               $display("FAIL %s_seq cyc=%0d got v=%b pc=%h i=%h want pc=%h", nm, c, id_valid, id_pc, id_instr, 4 * (c - 2));
            end
         end
         clock_edge();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] nxt;
      test_reset();
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, 1'b0, '0, 1'b0);
         model_eval();
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++; $display("FAIL bp_fill cyc=%0d got %h want %h", c, obs(), expv());
         end
         if (c >= 3) begin
            n_cmp++;
            if ({imem_req, pc_next, id_valid, id_pc} !== {1'b0, 32'h8, 1'b1, 32'h0}) begin
               n_bad++;
               $display("FAIL bp_stall cyc=%0d got rq=%b pn=%h v=%b pc=%h want rq=0 pn=8 v=1 pc=0", c, imem_req, pc_next, id_valid, id_pc);
            end
         end
         clock_edge();
      end
      nxt = 32'h0;
      for (int c = 0; c < 8; c++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         model_eval();
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++; $display("FAIL bp_drain cyc=%0d got %h want %h", c, obs(), expv());
         end
         n_cmp++;
         if ({id_valid, id_pc} !== {1'b1, nxt}) begin
            n_bad++; $display("FAIL bp_order cyc=%0d got v=%b pc=%h want v=1 pc=%h", c, id_valid, id_pc, nxt);
         end
         nxt += 32'd4;
         clock_edge();
      end
   endtask

   // Redirect in cycle k, then track id_valid gap and the first target.
   task automatic test_redirect(input string nm, input logic [31:0] tgt);
      logic [31:0] al;
      al = {tgt[31:2], 2'b00};
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, c == 0, tgt, 1'b1);
         model_eval();
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++; $display("FAIL %s_model cyc=%0d got %h want %h", nm, c, obs(), expv());
         end
         if (c == 0) begin
            n_cmp++;
            if (pc_next !== al) begin
               n_bad++; $display("FAIL %s_pcnext got %h want %h", nm, pc_next, al);
            end
         end
         if (c == 1) begin
            n_cmp++;
            if ({imem_req, imem_addr, pc_next} !== {1'b1, al, al + 32'd4}) begin
               n_bad++; $display("FAIL %s_issue got rq=%b a=%h pn=%h want rq=1 a=%h pn=%h", nm, imem_req, imem_addr, pc_next, al, al + 32'd4);
            end
         end
         if (c == 1 || c == 2) begin
            n_cmp++;
            if (id_valid !== 1'b0) begin
               n_bad++; $display("FAIL %s_gap cyc=%0d got v=%b want 0", nm, c, id_valid);
            end
         end
         if (c == 3) begin
            n_cmp++;
            if ({id_valid, id_pc, id_pc_plus4} !== {1'b1, al, al + 32'd4}) begin
               n_bad++; $display("FAIL %s_target got v=%b pc=%h p4=%h want pc=%h p4=%h", nm, id_valid, id_pc, id_pc_plus4, al, al + 32'd4);
            end
         end
         clock_edge();
      end
   endtask

   task automatic test_redirect_pop();
      n_cmp++;
      drive(1'b0, 1'b0, '0, 1'b1);
      if (id_valid !== 1'b1) begin
         n_bad++; $display("FAIL rpop_head got v=%b want 1", id_valid);
      end
      test_redirect("rpop", 32'h00000203);
   endtask

   task automatic test_async_reset();
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 1'b0, '0, 1'b0);
         model_eval();
         clock_edge();
      end
      n_cmp++;
      if ({id_valid, imem_req} !== 2'b10) begin
         n_bad++; $display("FAIL arst_pre got v=%b rq=%b want v=1 rq=0", id_valid, imem_req);
      end
      drive(1'b0, 1'b0, '0, 1'b1);
      n_cmp++;
      if ({id_valid, imem_req} !== 2'b11) begin
         n_bad++; $display("FAIL arst_ready got v=%b rq=%b want v=1 rq=1", id_valid, imem_req);
      end
      drive(1'b1, 1'b0, '0, 1'b1);
      model_eval();
      n_cmp++;
      if ({id_valid, imem_req, id_instr, id_pc, pc_next} !== {1'b0, 1'b0, NOP, 32'h0, pc}) begin
         n_bad++; $display("FAIL arst_async got v=%b rq=%b i=%h p=%h pn=%h want v=0 rq=0", id_valid, imem_req, id_instr, id_pc, pc_next);
      end
      n_cmp++;
      if (obs() !== expv()) begin
         n_bad++; $display("FAIL arst_model got %h want %h", obs(), expv());
      end
      clock_edge();
      test_stream("arst_restart");
   endtask

   task automatic test_random();
      salt = $urandom;
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 8, $urandom, $urandom_range(0, 9) < 7);
         model_eval();
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++; $display("FAIL random cyc=%0d got %h want %h", c, obs(), expv());
         end
         clock_edge();
      end
      drive(1'b0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_stream("stream");
      test_backpressure();
      drive(1'b0, 1'b0, '0, 1'b1);
      model_eval();
      clock_edge();
      test_redirect("redir", 32'h00000100);
      test_redirect("wrap", 32'hFFFFFFFC);
      test_redirect_pop();
      test_reset();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
